game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Parametrised successor to the top-level game-flow controller: owns the WELCOME -> START -> PLAY <-> PAUSE -> FINISH sequence and team-name entry.
- Generalised name length, character range, start countdown, finish lockout and button auto-repeat.
- Sits between the debounced button inputs and the time_remaining / orders_and_points / action blocks; drives their timer_go / restart controls and the HUD text.

Parameters:
NAME_LEN, 3, number of team-name characters (1..8)
CHAR_MIN, 8'h41, lowest legal character ('A')
CHAR_MAX, 8'h5A, highest legal character ('Z')
START_FRAMES, 300, frames spent in START before PLAY
FINISH_LOCK_FRAMES, 60, frames in FINISH during which buttons are ignored
REPEAT_DELAY, 20, frames up/down must be held before first auto-repeat
REPEAT_RATE, 6, frames between subsequent auto-repeats

Ports:
vsync  in  1  clock; all state updates on falling edge
reset  in  1  asynchronous, active-low reset
pause  in  1  level: high requests pause
left, right, up, down, chop  in  1 each  debounced button levels
time_up  in  1  high when time_left == 0
team_name  out  NAME_LEN x 8  characters; index NAME_LEN-1 is leftmost
cursor  out  $clog2(NAME_LEN)+1  selected character, 0 = leftmost
game_state  out  3  0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH
start_count  out  16  frames remaining in START
timer_go  out  1  enables time_remaining countdown
restart_timer  out  1  holds time_remaining at full time

Behaviour:
- Reset (asynchronous, low), outputs:
  - game_state = WELCOME, every team_name char = CHAR_MIN, cursor = 0.
  - start_count = START_FRAMES, timer_go = 0, restart_timer = 1.
  - All edge and repeat history cleared.
  - Reset asserted in any state takes effect immediately.
- Events, per frame:
  - press = button 1 this frame, 0 last frame.
  - up/down also produce a repeat event after REPEAT_DELAY consecutive held frames, then every REPEAT_RATE frames while held.
  - Release clears the repeat counter.
  - A held button never generates a second press.
- WELCOME (one action per frame, priority chop > up > down > right > left):
  - chop press: go to START; start_count = START_FRAMES; restart_timer = 1.
  - up event: selected char -1; CHAR_MIN wraps to CHAR_MAX.
  - down event: selected char +1; CHAR_MAX wraps to CHAR_MIN.
  - right press: cursor +1, saturating at NAME_LEN-1.
  - left press: cursor -1, saturating at 0.
  - Only the selected char changes; all others hold.
- START:
  - start_count decrements once per frame.
  - On the frame start_count == 0: go to PLAY, restart_timer = 0, timer_go = 1.
  - All buttons, pause and time_up are ignored.
- PLAY: timer_go = 1.
  - time_up = 1: go to FINISH, timer_go = 0. time_up wins over pause in the same frame.
  - Else pause = 1: go to PAUSE, timer_go = 0.
- PAUSE: timer_go = 0.
  - pause = 0: return to PLAY, timer_go = 1.
  - time_up is ignored.
- FINISH: timer_go = 0.
  - A lock counter loads FINISH_LOCK_FRAMES on entry and decrements each frame.
  - While the counter is nonzero, presses are ignored.
  - After that, any press (left/right/up/down/chop) goes to WELCOME: restart_timer = 1, cursor = 0, team_name retained.
  - A button already held through lockout does not count; a fresh press is required.
- Counters saturate at 0. No state encoding outside 0..4 is reachable; any such value returns to WELCOME on the next frame.

Decomposition:
- Package game_pkg:
  - game_state_t enum (WELCOME, START, PLAY, PAUSE, FINISH).
  - CHAR_MIN/CHAR_MAX defaults and the state width constant, shared with action and the HUD renderer.
- One sub-module, button_event: per-button press detect plus optional auto-repeat (REPEAT_DELAY, REPEAT_RATE, enable bit).
  - Five instances: repeat enabled only on up and down.

Test Plan:
- Reset low mid-PLAY -> same frame game_state=0, team_name all 8'h41, timer_go=0, restart_timer=1, cursor=0.
- In WELCOME: up press at cursor 0 -> team_name[2]=8'h5A; right, down x2 -> team_name[1]=8'h43, team_name[2] unchanged; right x5 -> cursor stays 2.
- Hold down 40 frames at cursor 0 from 'A' -> 1 press + repeats at frames 20, 26, 32, 38 -> team_name[2]=8'h46.
- chop press -> START for exactly START_FRAMES+1 frames, start_count 300..0, then PLAY with timer_go=1, restart_timer=0; chop/pause during START ignored.
- In PLAY: pause=1 -> PAUSE, timer_go=0; pause=0 -> PLAY; pause=1 and time_up=1 in the same frame -> FINISH.
- FINISH: chop press at frame 30 ignored; fresh press at frame 61 -> WELCOME with name retained and cursor 0; a button held continuously from entry -> no transition.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-flow types and constants.
// Used by the flow controller, the action block and the HUD renderer.
package game_pkg;

   localparam int STATE_W = 3;

   localparam logic [7:0] CHAR_MIN_DEF = 8'h41;
   localparam logic [7:0] CHAR_MAX_DEF = 8'h5A;

   // Bit positions of the buttons inside the packed button vector
   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;
   localparam int BTN_CHOP  = 4;
   localparam int NUM_BTN   = 5;

   typedef enum logic [STATE_W-1:0] {
      WELCOME = 3'd0,
      START   = 3'd1,
      PLAY    = 3'd2,
      PAUSE   = 3'd3,
      FINISH  = 3'd4
   } game_state_t;

   function automatic logic [7:0] char_step(input logic [7:0] c, input logic inc,
                                            input logic [7:0] lo, input logic [7:0] hi);
      if (inc) begin
         return (c >= hi) ? lo : c + 8'd1;
      end
      return (c <= lo) ? hi : c - 8'd1;
   endfunction

endpackage

// File: rtl/button_event.sv
// Per-button press detector with optional hold-to-repeat.
// evt pulses on the press and, when enabled, on every auto-repeat while held.
module button_event #(
   parameter int REPEAT_DELAY = 20,
   parameter int REPEAT_RATE  = 6,
   parameter bit REPEAT_EN    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press,
   output logic evt
);

   localparam logic [15:0] DELAY_LD = 16'(REPEAT_DELAY - 1);
   localparam logic [15:0] RATE_LD  = 16'(REPEAT_RATE);

   logic        btn_q;
   logic [15:0] rpt_q;
   logic [15:0] rpt_d;
   logic        rpt_hit;

   // rpt_q counts down the held frames left until the next repeat fires
   always_comb begin
      press   = btn & ~btn_q;
      rpt_hit = 1'b0;
      rpt_d   = rpt_q;
      if (!btn) begin
         rpt_d = '0;
      end else if (press) begin
         rpt_d = DELAY_LD;
      end else if (rpt_q <= 16'd1) begin
         rpt_hit = REPEAT_EN;
         rpt_d   = RATE_LD;
      end else begin
         rpt_d = rpt_q - 16'd1;
      end
      evt = press | rpt_hit;
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q <= 1'b0;
         rpt_q <= '0;
      end else begin
         btn_q <= btn;
         rpt_q <= rpt_d;
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow: WELCOME -> START -> PLAY <-> PAUSE -> FINISH.
// Also handles team-name entry. All state advances on the falling edge of vsync.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int         NAME_LEN           = 3,
   parameter logic [7:0] CHAR_MIN           = CHAR_MIN_DEF,
   parameter logic [7:0] CHAR_MAX           = CHAR_MAX_DEF,
   parameter int         START_FRAMES       = 300,
   parameter int         FINISH_LOCK_FRAMES = 60,
   parameter int         REPEAT_DELAY       = 20,
   parameter int         REPEAT_RATE        = 6
) (
   input  logic                       vsync,
   input  logic                       reset,
   input  logic                       pause,
   input  logic                       left,
   input  logic                       right,
   input  logic                       up,
   input  logic                       down,
   input  logic                       chop,
   input  logic                       time_up,
   output logic [NAME_LEN-1:0][7:0]   team_name,
   output logic [$clog2(NAME_LEN):0]  cursor,
   output logic [STATE_W-1:0]         game_state,
   output logic [15:0]                start_count,
   output logic                       timer_go,
   output logic                       restart_timer
);

   localparam int             CW       = $clog2(NAME_LEN) + 1;
   localparam logic [CW-1:0]  CUR_MAX  = CW'(NAME_LEN - 1);
   localparam logic [CW-1:0]  CUR_ONE  = CW'(1);
   localparam logic [15:0]    START_LD = 16'(START_FRAMES);
   localparam logic [15:0]    LOCK_LD  = 16'(FINISH_LOCK_FRAMES);

   game_state_t               state_q, state_d;
   logic [NAME_LEN-1:0][7:0]  name_q, name_d;
   logic [CW-1:0]             cursor_q, cursor_d;
   logic [15:0]               start_cnt_q, start_cnt_d;
   logic [15:0]               lock_q, lock_d;
   logic                      timer_go_q, timer_go_d;
   logic                      restart_q, restart_d;
   int                        sel_idx;

   logic [NUM_BTN-1:0]        btn_vec;
   logic [NUM_BTN-1:0]        press_vec;
   logic [NUM_BTN-1:0]        evt_vec;

   assign btn_vec = {chop, down, up, right, left};

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_event #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE),
         .REPEAT_EN    ((gi == BTN_UP) || (gi == BTN_DOWN))
      ) u_btn (
         .clk   (vsync),
         .rst_n (reset),
         .btn   (btn_vec[gi]),
         .press (press_vec[gi]),
         .evt   (evt_vec[gi])
      );
   end

   always_comb begin
      state_d     = state_q;
      name_d      = name_q;
      cursor_d    = cursor_q;
      start_cnt_d = start_cnt_q;
      lock_d      = lock_q;
      timer_go_d  = timer_go_q;
      restart_d   = restart_q;
      // Cursor 0 is the leftmost character, which lives at the top index
      sel_idx     = NAME_LEN - 1 - int'(cursor_q);

      case (state_q)
         WELCOME: begin
            timer_go_d = 1'b0;
            restart_d  = 1'b1;
            if (evt_vec[BTN_CHOP]) begin
               state_d     = START;
               start_cnt_d = START_LD;
            end else if (evt_vec[BTN_UP] || evt_vec[BTN_DOWN]) begin
               for (int i = 0; i < NAME_LEN; i++) begin
                  if (i == sel_idx) begin
                     name_d[i] = char_step(name_q[i], !evt_vec[BTN_UP], CHAR_MIN, CHAR_MAX);
                  end
               end
            end else if (evt_vec[BTN_RIGHT]) begin
               if (cursor_q < CUR_MAX) cursor_d = cursor_q + CUR_ONE;
            end else if (evt_vec[BTN_LEFT]) begin
               if (cursor_q != '0) cursor_d = cursor_q - CUR_ONE;
            end
         end

         START: begin
            timer_go_d = 1'b0;
            restart_d  = 1'b1;
            if (start_cnt_q == 16'd0) begin
               state_d    = PLAY;
               restart_d  = 1'b0;
               timer_go_d = 1'b1;
            end else begin
               start_cnt_d = start_cnt_q - 16'd1;
            end
         end

         PLAY: begin
            timer_go_d = 1'b1;
            restart_d  = 1'b0;
            if (time_up) begin
               state_d    = FINISH;
               timer_go_d = 1'b0;
               lock_d     = LOCK_LD;
            end else if (pause) begin
               state_d    = PAUSE;
               timer_go_d = 1'b0;
            end
         end

         PAUSE: begin
            timer_go_d = 1'b0;
            restart_d  = 1'b0;
            if (!pause) begin
               state_d    = PLAY;
               timer_go_d = 1'b1;
            end
         end

         FINISH: begin
            timer_go_d = 1'b0;
            restart_d  = 1'b0;
            if (lock_q != 16'd0) begin
               lock_d = lock_q - 16'd1;
            end else if (|press_vec) begin
               state_d   = WELCOME;
               restart_d = 1'b1;
               cursor_d  = '0;
            end
         end

         default: begin
            state_d    = WELCOME;
            timer_go_d = 1'b0;
            restart_d  = 1'b1;
            cursor_d   = '0;
         end
      endcase
   end

   always_ff @(negedge vsync or negedge reset) begin
      if (!reset) begin
         state_q     <= WELCOME;
         name_q      <= {NAME_LEN{CHAR_MIN}};
         cursor_q    <= '0;
         start_cnt_q <= START_LD;
         lock_q      <= '0;
         timer_go_q  <= 1'b0;
         restart_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         name_q      <= name_d;
         cursor_q    <= cursor_d;
         start_cnt_q <= start_cnt_d;
         lock_q      <= lock_d;
         timer_go_q  <= timer_go_d;
         restart_q   <= restart_d;
      end
   end

   assign team_name     = name_q;
   assign cursor        = cursor_q;
   assign game_state    = state_q;
   assign start_count   = start_cnt_q;
   assign timer_go      = timer_go_q;
   assign restart_timer = restart_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with default parameters.
// Each frame's expectation is queued with its stimulus and compared after the falling edge.
module tb_game_flow_ctrl;

   localparam logic [4:0] B_0 = 5'b00000;
   localparam logic [4:0] B_L = 5'b00001;
   localparam logic [4:0] B_R = 5'b00010;
   localparam logic [4:0] B_U = 5'b00100;
   localparam logic [4:0] B_D = 5'b01000;
   localparam logic [4:0] B_C = 5'b10000;

   logic           vsync;
   logic           reset;
   logic           pause, left, right, up, down, chop, time_up;
   logic [2:0][7:0] team_name;
   logic [2:0]     cursor;
   logic [2:0]     game_state;
   logic [15:0]    start_count;
   logic           timer_go;
   logic           restart_timer;

   game_flow_ctrl dut (
      .vsync         (vsync),
      .reset         (reset),
      .pause         (pause),
      .left          (left),
      .right         (right),
      .up            (up),
      .down          (down),
      .chop          (chop),
      .time_up       (time_up),
      .team_name     (team_name),
      .cursor        (cursor),
      .game_state    (game_state),
      .start_count   (start_count),
      .timer_go      (timer_go),
      .restart_timer (restart_timer)
   );

   typedef struct {
      string       tag;
      logic [4:0]  btn;
      logic        pause;
      logic        time_up;
      logic [2:0]  st;
      logic [23:0] name;
      logic [2:0]  cur;
   } vec_t;

   typedef struct {
      string       tag;
      logic [2:0]  st;
      logic [23:0] name;
      logic [2:0]  cur;
      logic        tg;
      logic        rt;
      bit          chk_sc;
      logic [15:0] sc;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial vsync = 1'b1;
   always #5 vsync = ~vsync;

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s %s: actual %0h required %0h", tag, fld, act, req);
      end
   endtask

   task automatic drive(input logic [4:0] b, input logic p, input logic tu);
      {chop, down, up, right, left} = b;
      pause   = p;
      time_up = tu;
   endtask

   task automatic frame();
      @(negedge vsync);
      @(posedge vsync);
   endtask

   function automatic exp_t mk(input string tag, input logic [2:0] st, input logic [23:0] name,
                               input logic [2:0] cur, input logic tg, input logic rt,
                               input bit chk_sc, input logic [15:0] sc);
      exp_t e;
      e.tag = tag; e.st = st; e.name = name; e.cur = cur;
      e.tg = tg; e.rt = rt; e.chk_sc = chk_sc; e.sc = sc;
      return e;
   endfunction

   function automatic void add(input string tag, input logic [4:0] b, input logic p,
                               input logic [2:0] st, input logic [23:0] name, input logic [2:0] cur);
      vec_t v;
      v.tag = tag; v.btn = b; v.pause = p; v.time_up = p;
      v.st = st; v.name = name; v.cur = cur;
      vecs.push_back(v);
   endfunction

   task automatic sb_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: actual empty required entry");
         return;
      end
      e = sb_q.pop_front();
      $display("txn %s st=%0d name=%h cur=%0d sc=%0d tg=%b rt=%b", e.tag, game_state, team_name,
               cursor, start_count, timer_go, restart_timer);
      cmp(e.tag, "game_state", 32'(game_state), 32'(e.st));
      cmp(e.tag, "team_name", 32'(team_name), 32'(e.name));
      cmp(e.tag, "cursor", 32'(cursor), 32'(e.cur));
      cmp(e.tag, "timer_go", 32'(timer_go), 32'(e.tg));
      cmp(e.tag, "restart_timer", 32'(restart_timer), 32'(e.rt));
      if (e.chk_sc) cmp(e.tag, "start_count", 32'(start_count), 32'(e.sc));
   endtask

   task automatic step(input logic [4:0] b, input logic p, input logic tu, input exp_t e);
      drive(b, p, tu);
      sb_q.push_back(e);
      frame();
      sb_check();
   endtask

   // 301 frames in START with buttons, pause and time_up chattering, then PLAY
   task automatic run_start(input logic [23:0] nm, input logic [2:0] cur);
      for (int i = 1; i <= 300; i++) begin
         step({(i % 2 == 1), 1'b0, (i % 7 == 0), 2'b00}, (i % 3 == 0) && (i != 300), (i % 5 == 0),
              mk("start", 3'd1, nm, cur, 1'b0, 1'b1, 1'b1, 16'(300 - i)));
      end
      step(B_0, 1'b0, 1'b0, mk("start_to_play", 3'd2, nm, cur, 1'b1, 1'b0, 1'b1, 16'd0));
   endtask

   initial begin
      logic [23:0] nm;
      int          ev;

      reset = 1'b0;
      drive(B_0, 1'b0, 1'b0);
      repeat (2) @(posedge vsync);
      sb_q.push_back(mk("reset", 3'd0, 24'h414141, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));
      sb_check();
      reset = 1'b1;

      // Hold down 40 frames: press at 1, repeats at 20, 26, 32, 38
      for (int k = 1; k <= 40; k++) begin
         ev = 1 + ((k >= 20) ? 1 + (k - 20) / 6 : 0);
         step(B_D, 1'b0, 1'b0, mk("hold_down", 3'd0, {8'(8'h41 + ev), 16'h4141}, 3'd0,
                                  1'b0, 1'b1, 1'b1, 16'd300));
      end
      step(B_0, 1'b0, 1'b0, mk("hold_release", 3'd0, 24'h464141, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));

      #2 reset = 1'b0;
      #1;
      sb_q.push_back(mk("rst_welcome", 3'd0, 24'h414141, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));
      sb_check();
      reset = 1'b1;

      add("up_c0",      B_U,       1'b0, 3'd0, 24'h5A4141, 3'd0);
      add("idle",       B_0,       1'b1, 3'd0, 24'h5A4141, 3'd0);
      add("right",      B_R,       1'b0, 3'd0, 24'h5A4141, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4141, 3'd1);
      add("down_c1",    B_D,       1'b0, 3'd0, 24'h5A4241, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4241, 3'd1);
      add("down_c1b",   B_D,       1'b0, 3'd0, 24'h5A4341, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4341, 3'd1);
      for (int i = 0; i < 5; i++) begin
         add("right_sat", B_R,      1'b0, 3'd0, 24'h5A4341, 3'd2);
         add("idle",      B_0,      1'b0, 3'd0, 24'h5A4341, 3'd2);
      end
      add("left",       B_L,       1'b0, 3'd0, 24'h5A4341, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4341, 3'd1);
      add("left",       B_L,       1'b0, 3'd0, 24'h5A4341, 3'd0);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4341, 3'd0);
      add("left_sat",   B_L,       1'b0, 3'd0, 24'h5A4341, 3'd0);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4341, 3'd0);
      add("right",      B_R,       1'b0, 3'd0, 24'h5A4341, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4341, 3'd1);
      add("up_over_dn", B_U | B_D, 1'b0, 3'd0, 24'h5A4241, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4241, 3'd1);
      add("rt_over_lf", B_R | B_L, 1'b0, 3'd0, 24'h5A4241, 3'd2);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4241, 3'd2);
      add("left",       B_L,       1'b0, 3'd0, 24'h5A4241, 3'd1);
      add("idle",       B_0,       1'b0, 3'd0, 24'h5A4241, 3'd1);
      add("chop_over_up", B_C | B_U, 1'b0, 3'd1, 24'h5A4241, 3'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].btn, vecs[i].pause, vecs[i].time_up,
              mk(vecs[i].tag, vecs[i].st, vecs[i].name, vecs[i].cur, 1'b0, 1'b1, 1'b1, 16'd300));
      end

      nm = 24'h5A4241;
      run_start(nm, 3'd1);

      step(B_0, 1'b0, 1'b0, mk("play_idle",   3'd2, nm, 3'd1, 1'b1, 1'b0, 1'b1, 16'd0));
      step(B_0, 1'b1, 1'b0, mk("pause",       3'd3, nm, 3'd1, 1'b0, 1'b0, 1'b1, 16'd0));
      step(B_0, 1'b1, 1'b1, mk("pause_tu",    3'd3, nm, 3'd1, 1'b0, 1'b0, 1'b1, 16'd0));
      step(B_0, 1'b0, 1'b0, mk("unpause",     3'd2, nm, 3'd1, 1'b1, 1'b0, 1'b1, 16'd0));
      step(B_0, 1'b1, 1'b1, mk("tu_over_p",   3'd4, nm, 3'd1, 1'b0, 1'b0, 1'b1, 16'd0));

      for (int f = 1; f <= 60; f++) begin
         step((f == 30) ? B_C : B_0, 1'b0, 1'b0,
              mk("finish_lock", 3'd4, nm, 3'd1, 1'b0, 1'b0, 1'b1, 16'd0));
      end
      step(B_C, 1'b0, 1'b0, mk("finish_f61",  3'd0, nm, 3'd0, 1'b0, 1'b1, 1'b1, 16'd0));
      step(B_0, 1'b0, 1'b0, mk("welcome",     3'd0, nm, 3'd0, 1'b0, 1'b1, 1'b1, 16'd0));
      step(B_C, 1'b0, 1'b0, mk("chop2",       3'd1, nm, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));
      run_start(nm, 3'd0);

      step(B_R, 1'b0, 1'b1, mk("finish_held_in", 3'd4, nm, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0));
      for (int f = 1; f <= 80; f++) begin
         step(B_R | ((f == 60) ? B_L : B_0), 1'b0, 1'b0,
              mk("finish_held", 3'd4, nm, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0));
      end
      step(B_0, 1'b0, 1'b0, mk("finish_release", 3'd4, nm, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0));
      step(B_D, 1'b0, 1'b0, mk("finish_fresh",   3'd0, nm, 3'd0, 1'b0, 1'b1, 1'b1, 16'd0));
      step(B_0, 1'b0, 1'b0, mk("welcome",        3'd0, nm, 3'd0, 1'b0, 1'b1, 1'b1, 16'd0));
      step(B_C, 1'b0, 1'b0, mk("chop3",          3'd1, nm, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));
      run_start(nm, 3'd0);
      step(B_0, 1'b0, 1'b0, mk("play_idle",      3'd2, nm, 3'd0, 1'b1, 1'b0, 1'b1, 16'd0));

      // Asynchronous reset mid-PLAY, checked before the next vsync edge
      #2 reset = 1'b0;
      #1;
      sb_q.push_back(mk("rst_play", 3'd0, 24'h414141, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));
      sb_check();
      sb_q.push_back(mk("rst_held", 3'd0, 24'h414141, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));
      frame();
      sb_check();
      reset = 1'b1;
      step(B_0, 1'b0, 1'b0, mk("post_rst", 3'd0, 24'h414141, 3'd0, 1'b0, 1'b1, 1'b1, 16'd300));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
